// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous pin inputs, with a selectable reset value.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even parity bit and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    logic rxs;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rxs)
    );

    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]                data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      tick;
    logic                      deliver;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q, par_bad_d;
    logic                      parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        tick = (cnt_q == '0);
        if (!tick) cnt_d = cnt_q - 1'b1;
        if (valid_q && ready) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = HALF_M1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL_M1;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    cnt_d          = FULL_M1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_bad_d = rxs ^ (^shift_q);
                    cnt_d     = FULL_M1;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so a following start edge is seen immediately.
                if (tick) begin
                    if (rxs) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A same-cycle handshake frees the holding register for the new byte.
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = par_bad_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialized by tasks, expected events
// (byte, frame error, overrun) are queued with their cycle and checked by a monitor.
module tb_uart_rx;

    localparam int unsigned N = 16;
    localparam int unsigned H = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FB = 10;
`else
    localparam int unsigned FB = 9;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = byte delivered, 1 = frame error, 2 = overrun
    typedef struct {
        int          kind;
        logic [7:0]  data;
        int unsigned cyc;
        logic        perr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   model_full = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_ready(logic r);
        ready = r;
        if (r) model_full = 1'b0;
    endtask

    // Expected outcome follows from the frame contents and the consumer state alone.
    task automatic send_frame(logic [7:0] b, logic stop_ok, logic par_flip);
        exp_t e;
        e.data = b;
        e.perr = par_flip;
        e.cyc  = cyc + 2 + H + FB * N + 1;
        if (!stop_ok) begin
            e.kind = 1;
        end else if (model_full && !ready) begin
            e.kind = 2;
        end else begin
            e.kind     = 0;
            model_full = !ready;
        end
        sb.push_back(e);
        rx = 1'b0;
        step(N);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(N);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        step(N);
`endif
        rx = stop_ok;
        step(N);
    endtask

    task automatic handle(int kind);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
            return;
        end
        e = sb.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (kind == 0) begin
            check("rx_data", {24'd0, data}, {24'd0, e.data});
`ifdef UART_RX_PARITY_EN
            check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
        end
    endtask

    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_err) handle(1);
            if (overrun) handle(2);
            if (valid && (!prev_valid || prev_ready)) begin
                handle(0);
            end else if (parity_err) begin
                tests++;
                fails++;
                $display("FAIL stray_parity_err: got 1 at cycle %0d expected 0", cyc);
            end
        end
        prev_valid <= valid;
        prev_ready <= ready;
    end

    initial begin
        logic [7:0] third;
        logic [7:0] b;
        logic       stop_ok;
        logic       pf;

        @(posedge clk);
        #2;
        step(4);
        check("reset_data", {24'd0, data}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        step(4);

        set_ready(1'b1);
        send_frame(8'hA5, 1'b1, 1'b0);
        step(20);

        rx = 1'b0;
        step(5);
        rx = 1'b1;
        step(40);
        check("glitch_valid", {31'd0, valid}, 32'd0);

        send_frame(8'h3C, 1'b0, 1'b0);
        step(40);
        check("break_valid", {31'd0, valid}, 32'd0);
        rx = 1'b1;
        step(10);

        set_ready(1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        step(10);
        check("hold_valid", {31'd0, valid}, 32'd1);
        check("hold_data", {24'd0, data}, 32'h11);
        set_ready(1'b1);
        step(2);
        check("accept_clears_valid", {31'd0, valid}, 32'd0);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        third = 8'hF5;
        rx = 1'b0;
        step(N);
        for (int i = 0; i < 4; i++) begin
            rx = third[i];
            step(N);
        end
        rx = third[4];
        step(N / 2);
        reset = 1'b0;
        step(3);
        check("midframe_reset_valid", {31'd0, valid}, 32'd0);
        check("midframe_reset_data", {24'd0, data}, 32'd0);
        reset      = 1'b1;
        model_full = 1'b0;
        rx         = 1'b1;
        step(N * 8);
        check("post_reset_valid", {31'd0, valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        step(10);
        send_frame(8'h07, 1'b1, 1'b0);
        step(10);
`endif

        for (int k = 0; k < 40; k++) begin
            b       = 8'($urandom);
            stop_ok = ($urandom_range(7) != 0);
            pf      = ($urandom_range(3) == 0);
            set_ready($urandom_range(3) != 0);
            send_frame(b, stop_ok, pf);
            if (!stop_ok) begin
                step($urandom_range(20));
                rx = 1'b1;
                step(4 + $urandom_range(5));
            end else begin
                step($urandom_range(12));
            end
        end

        step(200);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
